ram_mux_gen: RTL and testbench
==============================

Name: ram_mux_gen

Overview:
Parametrised successor to the DDR2 user-interface multiplexer: it arbitrates frame writes and block reads onto one memory-controller app port (address FIFO, write-data FIFO, read-data return). Write blocks of WR_BEATS words and read blocks of RD_BEATS words are generic. Adds FIFO almost-full backpressure, an auto-advancing read pointer with wrap, and a read-done handshake. Sits between the frame/network logic and the memory controller.

Parameters:
DATA_W, 128, controller data word width (one beat)
ADDR_W, 31, controller address width
WR_BEATS, 6, beats per write block; even, >=2
RD_BEATS, 48, beats per read block; even, >=2
ADDR_STEP, 4, address increment per command (burst-4, 2 beats per command)
FRAME_BASE, 0, read pointer value after new_frame
FRAME_SPAN, 4096, read pointer wraps to FRAME_BASE when it reaches FRAME_BASE+FRAME_SPAN

Ports:
clk0_tb  in  1  single clock
rst0_tb  in  1  reset, asynchronous, active-low
phy_init_done  in  1  controller calibration complete
app_af_afull  in  1  address FIFO almost full
app_wdf_afull  in  1  write-data FIFO almost full
cmd  out  3  3'b000 write, 3'b001 read
address  out  ADDR_W  command address
af_we  out  1  address FIFO write strobe
wdf_we  out  1  write-data FIFO write strobe
w_data  out  DATA_W  write beat
rd_data_valid  in  1  read beat valid
rd_data_fifo_out  in  DATA_W  read beat
write_ram  in  1  pulse: start write block
write_address  in  32  write block start address (low ADDR_W bits used)
write_data  in  WR_BEATS*DATA_W  write block, beat 0 in LSBs
ask_data  in  1  pulse: start read block
new_frame  in  1  pulse: reset read pointer
read_data  out  RD_BEATS*DATA_W  read block, beat 0 in LSBs
read_done  out  1  one-cycle pulse, read_data complete
busy  out  1  high outside IDLE
debug  out  8  {pending flags[3:0], state[3:0]}

Behaviour:
- Reset (rst0_tb low, async): cmd=0, address=0, af_we=0, wdf_we=0, w_data=0, read_data=0, read_done=0, busy=1, debug=0, read pointer=FRAME_BASE, pending flags clear, state INIT.
- INIT: wait phy_init_done=1, then IDLE (busy=0). write_ram/ask_data/new_frame during INIT set pending flags, serviced in IDLE.
- IDLE priority: new_frame (pointer:=FRAME_BASE, same cycle) > write > read. write_ram and ask_data together: WRITE first, read stays pending. new_frame with ask_data: pointer reset applies before the read.
- Requests arriving outside IDLE latch as pending (one deep each; repeats while pending are lost). new_frame pending applies on return to IDLE.
- WRITE: write_data and write_address captured on entry. For command k (0..WR_BEATS/2-1): cycle A: wdf_we=1, w_data=beat 2k, af_we=1, cmd=000, address=write_address+k*ADDR_STEP; cycle B: wdf_we=1, w_data=beat 2k+1, af_we=0. Before cycle A, app_af_afull or app_wdf_afull high -> hold, no strobes. Before cycle B, only app_wdf_afull stalls. Strobes never assert during a stall. After last cycle B -> IDLE.
- READ: issue RD_BEATS/2 commands, cmd=001, address=ptr+j*ADDR_STEP, af_we=1 each cycle unless app_af_afull (stall, af_we=0). Beat collection runs concurrently from entry: each rd_data_valid=1 stores rd_data_fifo_out at read_data[i*DATA_W +: DATA_W], i increments. After beat RD_BEATS-1 stored and all commands issued: read_done=1 next cycle, ptr += (RD_BEATS/2)*ADDR_STEP; if result >= FRAME_BASE+FRAME_SPAN, ptr:=FRAME_BASE; -> IDLE.
- rd_data_valid outside READ ignored; beats beyond RD_BEATS ignored.
- read_data holds until overwritten by next read; not cleared at read start.
- Address arithmetic modulo 2^ADDR_W.
- Reset mid-operation: immediate return to reset values; partial block discarded, no strobes.
- phy_init_done deassertion only observed in INIT.

Test Plan:
- Reset release, phy_init_done high after 200 ns -> busy 1->0, all strobes 0 before and after.
- write_ram, write_address=0x100, beats 0..5 = 0x10..0x15 -> 3 af_we pulses, addresses 0x100/0x104/0x108 cmd=000; 6 wdf_we beats 0x10..0x15 in order.
- Same write with app_wdf_afull high 3 cycles before beat 3 -> no strobe those cycles, data order intact, total 6 wdf_we, 3 af_we.
- new_frame then ask_data, return beats {64'dn,64'd0}, n=0..47 -> 24 reads at 0,4,..,92; read_data beat n matches; read_done single pulse; next read starts at 96.
- FRAME_SPAN=192: two reads -> second starts at 96, third at 0 (wrap).
- write_ram and ask_data same cycle -> full write completes first, then read; rst0_tb low mid-read -> read_done never pulses, outputs at reset values.

Source files
------------

// File: rtl/ram_mux_gen.sv
// ram_mux_gen: arbitrates block writes and block reads onto a single
// memory-controller app port (address FIFO, write-data FIFO, read return).
module ram_mux_gen #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned ADDR_W     = 31,
    parameter int unsigned WR_BEATS   = 6,
    parameter int unsigned RD_BEATS   = 48,
    parameter int unsigned ADDR_STEP  = 4,
    parameter int unsigned FRAME_BASE = 0,
    parameter int unsigned FRAME_SPAN = 4096
) (
    input  logic                         clk0_tb,
    input  logic                         rst0_tb,
    input  logic                         phy_init_done,
    input  logic                         app_af_afull,
    input  logic                         app_wdf_afull,
    output logic [2:0]                   cmd,
    output logic [ADDR_W-1:0]            address,
    output logic                         af_we,
    output logic                         wdf_we,
    output logic [DATA_W-1:0]            w_data,
    input  logic                         rd_data_valid,
    input  logic [DATA_W-1:0]            rd_data_fifo_out,
    input  logic                         write_ram,
    input  logic [31:0]                  write_address,
    input  logic [WR_BEATS*DATA_W-1:0]   write_data,
    input  logic                         ask_data,
    input  logic                         new_frame,
    output logic [RD_BEATS*DATA_W-1:0]   read_data,
    output logic                         read_done,
    output logic                         busy,
    output logic [7:0]                   debug
);

    localparam int unsigned NCMD = RD_BEATS / 2;
    localparam int unsigned WB_W = $clog2(WR_BEATS);
    localparam int unsigned RB_W = $clog2(RD_BEATS + 1);
    localparam int unsigned RC_W = $clog2(NCMD + 1);

    localparam logic [ADDR_W-1:0] STEP_A    = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(FRAME_BASE);
    localparam logic [ADDR_W-1:0] PTR_ADV   = ADDR_W'(NCMD * ADDR_STEP);
    localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W + 1)'(FRAME_BASE + FRAME_SPAN);

    typedef enum logic [3:0] {
        S_INIT  = 4'd0,
        S_IDLE  = 4'd1,
        S_WRITE = 4'd2,
        S_READ  = 4'd3
    } state_e;

    state_e                       state_q, state_d;
    logic [2:0]                   pend_q, pend_d;      // {new_frame, read, write}
    logic [ADDR_W-1:0]            ptr_q, ptr_d;
    logic [ADDR_W-1:0]            wr_addr_q, wr_addr_d;
    logic [WR_BEATS*DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [WB_W-1:0]              wr_beat_q, wr_beat_d;
    logic [ADDR_W-1:0]            rd_addr_q, rd_addr_d;
    logic [RC_W-1:0]              rd_cmd_q, rd_cmd_d;
    logic [RB_W-1:0]              rd_beat_q, rd_beat_d;
    logic [2:0]                   cmd_q, cmd_d;
    logic [ADDR_W-1:0]            address_q, address_d;
    logic                         af_we_q, af_we_d;
    logic                         wdf_we_q, wdf_we_d;
    logic [DATA_W-1:0]            w_data_q, w_data_d;
    logic [RD_BEATS*DATA_W-1:0]   read_data_q, read_data_d;
    logic                         read_done_q, read_done_d;
    logic                         busy_q, busy_d;

    logic                         nf_req_c, wr_req_c, rd_req_c;
    logic [ADDR_W-1:0]            ptr_next_c;
    logic                         unused_wr_addr_c;

    // Upper write_address bits beyond ADDR_W are intentionally dropped.
    assign unused_wr_addr_c = ^write_address;

    // Next-state, request arbitration and output decisions.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        ptr_d       = ptr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_beat_d   = wr_beat_q;
        rd_addr_d   = rd_addr_q;
        rd_cmd_d    = rd_cmd_q;
        rd_beat_d   = rd_beat_q;
        cmd_d       = cmd_q;
        address_d   = address_q;
        af_we_d     = 1'b0;
        wdf_we_d    = 1'b0;
        w_data_d    = w_data_q;
        read_data_d = read_data_q;
        read_done_d = 1'b0;

        nf_req_c   = new_frame | pend_q[2];
        rd_req_c   = ask_data  | pend_q[1];
        wr_req_c   = write_ram | pend_q[0];
        ptr_next_c = ptr_q + PTR_ADV;

        unique case (state_q)
            S_INIT: begin
                pend_d = pend_q | {new_frame, ask_data, write_ram};
                if (phy_init_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                pend_d = '0;
                if (nf_req_c) ptr_d = BASE_A;
                if (wr_req_c) begin
                    state_d   = S_WRITE;
                    wr_addr_d = ADDR_W'(write_address);
                    wr_data_d = write_data;
                    wr_beat_d = '0;
                    pend_d[1] = rd_req_c;
                end else if (rd_req_c) begin
                    state_d   = S_READ;
                    rd_addr_d = nf_req_c ? BASE_A : ptr_q;
                    rd_cmd_d  = '0;
                    rd_beat_d = '0;
                end
            end
            S_WRITE: begin
                pend_d = pend_q | {new_frame, ask_data, write_ram};
                if (!wr_beat_q[0]) begin
                    // Even beat carries the command; needs room in both FIFOs.
                    if (!app_af_afull && !app_wdf_afull) begin
                        af_we_d   = 1'b1;
                        wdf_we_d  = 1'b1;
                        cmd_d     = 3'b000;
                        address_d = wr_addr_q;
                        w_data_d  = wr_data_q[32'(wr_beat_q) * DATA_W +: DATA_W];
                        wr_addr_d = wr_addr_q + STEP_A;
                        wr_beat_d = wr_beat_q + WB_W'(1);
                    end
                end else if (!app_wdf_afull) begin
                    wdf_we_d = 1'b1;
                    w_data_d = wr_data_q[32'(wr_beat_q) * DATA_W +: DATA_W];
                    if (wr_beat_q == WB_W'(WR_BEATS - 1)) state_d = S_IDLE;
                    else wr_beat_d = wr_beat_q + WB_W'(1);
                end
            end
            S_READ: begin
                pend_d = pend_q | {new_frame, ask_data, write_ram};
                if (rd_cmd_q != RC_W'(NCMD) && !app_af_afull) begin
                    af_we_d   = 1'b1;
                    cmd_d     = 3'b001;
                    address_d = rd_addr_q;
                    rd_addr_d = rd_addr_q + STEP_A;
                    rd_cmd_d  = rd_cmd_q + RC_W'(1);
                end
                if (rd_data_valid && rd_beat_q != RB_W'(RD_BEATS)) begin
                    read_data_d[32'(rd_beat_q) * DATA_W +: DATA_W] = rd_data_fifo_out;
                    rd_beat_d = rd_beat_q + RB_W'(1);
                end
                if (rd_cmd_q == RC_W'(NCMD) && rd_beat_q == RB_W'(RD_BEATS)) begin
                    read_done_d = 1'b1;
                    ptr_d       = ({1'b0, ptr_next_c} >= FRAME_END) ? BASE_A : ptr_next_c;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset discards any partial block.
    always_ff @(posedge clk0_tb or negedge rst0_tb) begin
        if (!rst0_tb) begin
            state_q     <= S_INIT;
            pend_q      <= '0;
            ptr_q       <= BASE_A;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_beat_q   <= '0;
            rd_addr_q   <= '0;
            rd_cmd_q    <= '0;
            rd_beat_q   <= '0;
            cmd_q       <= '0;
            address_q   <= '0;
            af_we_q     <= 1'b0;
            wdf_we_q    <= 1'b0;
            w_data_q    <= '0;
            read_data_q <= '0;
            read_done_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            ptr_q       <= ptr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_beat_q   <= wr_beat_d;
            rd_addr_q   <= rd_addr_d;
            rd_cmd_q    <= rd_cmd_d;
            rd_beat_q   <= rd_beat_d;
            cmd_q       <= cmd_d;
            address_q   <= address_d;
            af_we_q     <= af_we_d;
            wdf_we_q    <= wdf_we_d;
            w_data_q    <= w_data_d;
            read_data_q <= read_data_d;
            read_done_q <= read_done_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd       = cmd_q;
    assign address   = address_q;
    assign af_we     = af_we_q;
    assign wdf_we    = wdf_we_q;
    assign w_data    = w_data_q;
    assign read_data = read_data_q;
    assign read_done = read_done_q;
    assign busy      = busy_q;
    assign debug     = {1'b0, pend_q, state_q};

endmodule

// File: tb/tb_ram_mux_gen.sv
// Testbench for ram_mux_gen: transaction model of expected app-port traffic
// and read blocks, checked by one monitor process, plus directed literals.
module tb_ram_mux_gen;

    localparam int unsigned DATA_W     = 128;
    localparam int unsigned ADDR_W     = 31;
    localparam int unsigned WR_BEATS   = 6;
    localparam int unsigned RD_BEATS   = 48;
    localparam int unsigned ADDR_STEP  = 4;
    localparam int unsigned FRAME_BASE = 0;
    localparam int unsigned FRAME_SPAN = 192;
    localparam int unsigned NCMD       = RD_BEATS / 2;

    logic                        clk0_tb = 1'b0;
    logic                        rst0_tb;
    logic                        phy_init_done, app_af_afull, app_wdf_afull;
    logic [2:0]                  cmd;
    logic [ADDR_W-1:0]           address;
    logic                        af_we, wdf_we;
    logic [DATA_W-1:0]           w_data;
    logic                        rd_data_valid;
    logic [DATA_W-1:0]           rd_data_fifo_out;
    logic                        write_ram;
    logic [31:0]                 write_address;
    logic [WR_BEATS*DATA_W-1:0]  write_data;
    logic                        ask_data, new_frame;
    logic [RD_BEATS*DATA_W-1:0]  read_data;
    logic                        read_done, busy;
    logic [7:0]                  debug;

    ram_mux_gen #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WR_BEATS(WR_BEATS), .RD_BEATS(RD_BEATS),
        .ADDR_STEP(ADDR_STEP), .FRAME_BASE(FRAME_BASE), .FRAME_SPAN(FRAME_SPAN)
    ) dut (
        .clk0_tb(clk0_tb), .rst0_tb(rst0_tb), .phy_init_done(phy_init_done),
        .app_af_afull(app_af_afull), .app_wdf_afull(app_wdf_afull),
        .cmd(cmd), .address(address), .af_we(af_we), .wdf_we(wdf_we), .w_data(w_data),
        .rd_data_valid(rd_data_valid), .rd_data_fifo_out(rd_data_fifo_out),
        .write_ram(write_ram), .write_address(write_address), .write_data(write_data),
        .ask_data(ask_data), .new_frame(new_frame), .read_data(read_data),
        .read_done(read_done), .busy(busy), .debug(debug)
    );

    always #5 clk0_tb = ~clk0_tb;

    typedef struct packed {
        logic [2:0]        cmd;
        logic [ADDR_W-1:0] addr;
    } af_t;

    af_t               exp_af[$];
    logic [DATA_W-1:0] exp_wdf[$];
    logic [ADDR_W-1:0] af_log[$];
    logic [DATA_W-1:0] m_rd [RD_BEATS];
    logic [ADDR_W-1:0] m_ptr;
    af_t               af_cur;
    logic [DATA_W-1:0] wdf_cur;
    int                errors = 0;
    int                checks = 0;
    int                done_cnt = 0;
    int                wdf_cnt = 0;
    logic              prev_done = 1'b0;
    logic              af_full_s = 1'b0;
    logic              wdf_full_s = 1'b0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [DATA_W-1:0] beat_val(input int r, input int n);
        return {64'(n + r * 256), 64'(r)};
    endfunction

    task automatic tick();
        @(posedge clk0_tb);
        #1;
    endtask

    // Model: a write block yields WR_BEATS/2 commands and WR_BEATS data beats.
    task automatic start_write(input logic [31:0] a, input int base);
        af_t e;
        write_address = a;
        for (int b = 0; b < WR_BEATS; b++) begin
            write_data[b*DATA_W +: DATA_W] = DATA_W'(base + b);
            exp_wdf.push_back(DATA_W'(base + b));
        end
        for (int k = 0; k < WR_BEATS / 2; k++) begin
            e.cmd  = 3'b000;
            e.addr = ADDR_W'(a) + ADDR_W'(k * ADDR_STEP);
            exp_af.push_back(e);
        end
    endtask

    // Model: a read block yields NCMD read commands from the frame pointer.
    task automatic model_read(input int r);
        af_t         e;
        int unsigned nxt;
        for (int j = 0; j < NCMD; j++) begin
            e.cmd  = 3'b001;
            e.addr = m_ptr + ADDR_W'(j * ADDR_STEP);
            exp_af.push_back(e);
        end
        for (int n = 0; n < RD_BEATS; n++) m_rd[n] = beat_val(r, n);
        nxt = 32'(m_ptr) + NCMD * ADDR_STEP;
        m_ptr = (nxt >= FRAME_BASE + FRAME_SPAN) ? ADDR_W'(FRAME_BASE) : ADDR_W'(nxt);
    endtask

    // Almost-full levels as seen by the DUT at each rising edge.
    always @(posedge clk0_tb) begin
        af_full_s  <= app_af_afull;
        wdf_full_s <= app_wdf_afull;
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk0_tb) begin
        if (!rst0_tb) begin
            check("rst_af_we", DATA_W'(af_we), '0);
            check("rst_wdf_we", DATA_W'(wdf_we), '0);
            check("rst_read_done", DATA_W'(read_done), '0);
            check("rst_busy", DATA_W'(busy), DATA_W'(1));
        end else begin
            if (af_we) begin
                check("af_we_in_stall", DATA_W'(af_full_s), '0);
                af_log.push_back(address);
                if (exp_af.size() == 0) begin
                    fail_msg("af_unexpected");
                end else begin
                    af_cur = exp_af.pop_front();
                    check("af_cmd", DATA_W'(cmd), DATA_W'(af_cur.cmd));
                    check("af_addr", DATA_W'(address), DATA_W'(af_cur.addr));
                end
            end
            if (wdf_we) begin
                wdf_cnt++;
                check("wdf_we_in_stall", DATA_W'(wdf_full_s), '0);
                if (exp_wdf.size() == 0) begin
                    fail_msg("wdf_unexpected");
                end else begin
                    wdf_cur = exp_wdf.pop_front();
                    check("wdf_data", w_data, wdf_cur);
                end
            end
            if (read_done) begin
                done_cnt++;
                check("read_done_pulse", DATA_W'(prev_done), '0);
                for (int b = 0; b < RD_BEATS; b++)
                    check("read_beat", read_data[b*DATA_W +: DATA_W], m_rd[b]);
            end
        end
        prev_done = read_done;
    end

    task automatic wait_idle(input string name);
        int g = 0;
        while (busy && g < 500) begin tick(); g++; end
        if (busy) fail_msg({name, "_timeout"});
    endtask

    task automatic wait_done(input string name, input int start);
        int g = 0;
        while (done_cnt == start && g < 300) begin tick(); g++; end
        if (done_cnt == start) fail_msg({name, "_timeout"});
        repeat (3) tick();
        check({name, "_done_count"}, DATA_W'(done_cnt - start), DATA_W'(1));
    endtask

    // Waits for the first read command, optionally stalls the address FIFO,
    // then returns RD_BEATS beats with gaps (plus an optional stray beat).
    task automatic feed_beats(input int r, input bit stall, input bit extra);
        int g = 0;
        while (!(af_we && cmd == 3'b001) && g < 100) begin tick(); g++; end
        if (g >= 100) fail_msg("rd_start_timeout");
        if (stall) begin
            app_af_afull = 1'b1;
            repeat (2) begin tick(); check("af_stall_no_we", DATA_W'(af_we), '0); end
            app_af_afull = 1'b0;
        end
        for (int n = 0; n < RD_BEATS; n++) begin
            if (n % 7 == 3) begin rd_data_valid = 1'b0; tick(); end
            rd_data_valid    = 1'b1;
            rd_data_fifo_out = beat_val(r, n);
            tick();
        end
        if (extra) begin rd_data_fifo_out = '1; tick(); end
        rd_data_valid = 1'b0;
    endtask

    task automatic check_drained(input string name);
        check({name, "_af_left"}, DATA_W'(exp_af.size()), '0);
        check({name, "_wdf_left"}, DATA_W'(exp_wdf.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        int w0;
        int d0;
        rst0_tb = 1'b1;
        phy_init_done = 1'b0; app_af_afull = 1'b0; app_wdf_afull = 1'b0;
        rd_data_valid = 1'b0; rd_data_fifo_out = '0; write_ram = 1'b0;
        write_address = '0; write_data = '0; ask_data = 1'b0; new_frame = 1'b0;
        m_ptr = ADDR_W'(FRAME_BASE);
        #2 rst0_tb = 1'b0;
        repeat (3) tick();
        check("reset_busy", DATA_W'(busy), DATA_W'(1));
        check("reset_debug", DATA_W'(debug), '0);
        check("reset_cmd", DATA_W'(cmd), '0);
        check("reset_address", DATA_W'(address), '0);

        // Calibration wait: stays busy until phy_init_done.
        rst0_tb = 1'b1;
        repeat (20) tick();
        check("init_busy", DATA_W'(busy), DATA_W'(1));
        check("init_af_we", DATA_W'(af_we), '0);
        phy_init_done = 1'b1;
        wait_idle("init");
        check("idle_busy", DATA_W'(busy), '0);

        // Plain write block at 0x100.
        af_log.delete(); w0 = wdf_cnt;
        start_write(32'h100, 'h10);
        write_ram = 1'b1; tick(); write_ram = 1'b0;
        tick();
        wait_idle("wr1"); tick();
        check_drained("wr1");
        check("wr1_af_count", DATA_W'(af_log.size()), DATA_W'(3));
        check("wr1_wdf_count", DATA_W'(wdf_cnt - w0), DATA_W'(6));
        if (af_log.size() == 3) begin
            check("wr1_addr0", DATA_W'(af_log[0]), DATA_W'('h100));
            check("wr1_addr1", DATA_W'(af_log[1]), DATA_W'('h104));
            check("wr1_addr2", DATA_W'(af_log[2]), DATA_W'('h108));
        end

        // Write block with write-data FIFO almost full before beat 3.
        af_log.delete(); w0 = wdf_cnt;
        start_write(32'h200, 'h20);
        write_ram = 1'b1; tick(); write_ram = 1'b0;
        n = 0; g = 0;
        while (n < 3 && g < 50) begin tick(); if (wdf_we) n++; g++; end
        if (n < 3) fail_msg("wr2_beats_timeout");
        app_wdf_afull = 1'b1;
        repeat (3) begin tick(); check("wr2_stall_no_wdf", DATA_W'(wdf_we), '0); end
        app_wdf_afull = 1'b0;
        wait_idle("wr2"); tick();
        check_drained("wr2");
        check("wr2_af_count", DATA_W'(af_log.size()), DATA_W'(3));
        check("wr2_wdf_count", DATA_W'(wdf_cnt - w0), DATA_W'(6));

        // new_frame then read block 0 from the frame base.
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        m_ptr = ADDR_W'(FRAME_BASE);
        af_log.delete(); d0 = done_cnt;
        model_read(0);
        ask_data = 1'b1; tick(); ask_data = 1'b0;
        feed_beats(0, 1'b0, 1'b0);
        wait_done("rd1", d0);
        check_drained("rd1");
        check("rd1_cmd_count", DATA_W'(af_log.size()), DATA_W'(NCMD));
        if (af_log.size() == NCMD) begin
            check("rd1_first_addr", DATA_W'(af_log[0]), '0);
            check("rd1_last_addr", DATA_W'(af_log[NCMD-1]), DATA_W'(92));
        end
        check("rd1_beat5", read_data[5*DATA_W +: DATA_W], {64'd5, 64'd0});

        // Read block 1: address FIFO stall and a stray beat past the block.
        af_log.delete(); d0 = done_cnt;
        model_read(1);
        ask_data = 1'b1; tick(); ask_data = 1'b0;
        feed_beats(1, 1'b1, 1'b1);
        wait_done("rd2", d0);
        check_drained("rd2");
        if (af_log.size() > 0) check("rd2_first_addr", DATA_W'(af_log[0]), DATA_W'(96));
        check("rd2_beat0", read_data[0 +: DATA_W], {64'd256, 64'd1});
        check("rd2_beat47_kept", read_data[47*DATA_W +: DATA_W], beat_val(1, 47));

        // Read block 2: pointer has wrapped back to the frame base.
        af_log.delete(); d0 = done_cnt;
        model_read(2);
        ask_data = 1'b1; tick(); ask_data = 1'b0;
        feed_beats(2, 1'b0, 1'b0);
        wait_done("rd3", d0);
        check_drained("rd3");
        if (af_log.size() > 0) check("rd3_wrap_addr", DATA_W'(af_log[0]), '0);

        // Write and read requested together: write goes first.
        af_log.delete(); d0 = done_cnt;
        start_write(32'h300, 'h30);
        model_read(3);
        write_ram = 1'b1; ask_data = 1'b1; tick(); write_ram = 1'b0; ask_data = 1'b0;
        feed_beats(3, 1'b0, 1'b0);
        wait_done("wr_rd", d0);
        check_drained("wr_rd");
        if (af_log.size() > 3) begin
            check("wr_rd_first_is_write", DATA_W'(af_log[0]), DATA_W'('h300));
            check("wr_rd_read_addr", DATA_W'(af_log[3]), DATA_W'(96));
        end

        // Reset in the middle of a read block.
        d0 = done_cnt;
        model_read(4);
        ask_data = 1'b1; tick(); ask_data = 1'b0;
        n = 0; g = 0;
        while (n < 5 && g < 50) begin tick(); if (af_we) n++; g++; end
        if (n < 5) fail_msg("rst_rd_start_timeout");
        rd_data_valid = 1'b1; rd_data_fifo_out = beat_val(4, 0); tick();
        rd_data_valid = 1'b0;
        rst0_tb = 1'b0;
        exp_af.delete(); exp_wdf.delete();
        m_ptr = ADDR_W'(FRAME_BASE);
        tick();
        check("midrst_cmd", DATA_W'(cmd), '0);
        check("midrst_address", DATA_W'(address), '0);
        check("midrst_w_data", w_data, '0);
        check("midrst_read_data", DATA_W'(|read_data), '0);
        check("midrst_debug", DATA_W'(debug), '0);
        repeat (3) tick();
        rst0_tb = 1'b1;
        repeat (20) tick();
        check("midrst_no_done", DATA_W'(done_cnt - d0), '0);
        check("midrst_idle", DATA_W'(busy), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
